// File: rtl/ready_valid_pkg.sv
// ready_valid_pkg: shared ready/valid types and the sink checker state enum
package ready_valid_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} rv_state_e;
    typedef logic [15:0] rv_count_t;
    typedef logic [2:0]  rv_phase_t;
    function automatic rv_count_t sat_inc(input rv_count_t c);
        return (c == '1) ? c : c + 16'd1;
    endfunction
endpackage

// File: rtl/rv_ready_pattern_gen.sv
// rv_ready_pattern_gen: registered in_ready driven from a latched 8-bit pattern
module rv_ready_pattern_gen
    import ready_valid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic       keep,
    input  logic [7:0] ready_pattern,
    output logic       in_ready
);
    logic [7:0] pat_q;
    rv_phase_t  phase;
    // phase tracks the pattern bit currently on in_ready; the next bit is registered ahead
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q    <= '0;
            phase    <= '0;
            in_ready <= 1'b0;
        end else if (load) begin
            pat_q    <= ready_pattern;
            phase    <= '0;
            in_ready <= ready_pattern[0];
        end else begin
            if (run) phase <= phase + 3'd1;
            in_ready <= keep ? pat_q[phase + 3'd1] : 1'b0;
        end
    end
endmodule

// File: rtl/ready_valid_sink_checker.sv
// ready_valid_sink_checker: accepts a counting stream under a ready pattern and reports errors
module ready_valid_sink_checker
    import ready_valid_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_EXPECTED = 16,
    parameter int START_VALUE  = 0,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            ready_pattern,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           rx_count,
    output logic [15:0]           error_count,
    output logic [15:0]           first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    rv_state_e state, state_n;
    rv_count_t watchdog;
    logic hs, launch, last_beat, expire, mismatch;
    assign hs        = in_valid && in_ready;
    assign launch    = start && state != RUN;
    assign last_beat = hs && rx_count == 16'(NUM_EXPECTED - 1);
    assign expire    = !hs && watchdog == 16'(TIMEOUT - 1);
    assign mismatch  = in_data != DATA_WIDTH'(START_VALUE) + DATA_WIDTH'(rx_count);
    assign busy      = state == RUN;
    assign done      = state == DONE;
    assign pass      = done && error_count == '0 && !timeout;
    rv_ready_pattern_gen u_pat (
        .clk           (clk),
        .reset         (reset),
        .load          (launch),
        .run           (busy),
        .keep          (busy && state_n == RUN),
        .ready_pattern (ready_pattern),
        .in_ready      (in_ready)
    );
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // next state: a final beat takes precedence over watchdog expiry
    always_comb begin
        state_n = state;
        if (launch) state_n = RUN;
        else if (busy && (last_beat || expire)) state_n = DONE;
    end
    // counters, watchdog and first-error capture; frozen outside RUN
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            rx_count        <= '0;
            error_count     <= '0;
            first_err_index <= '0;
            first_err_data  <= '0;
            timeout         <= 1'b0;
            watchdog        <= '0;
        end else if (busy) begin
            if (hs) begin
                rx_count <= rx_count + 16'd1;
                watchdog <= '0;
                if (mismatch) begin
                    error_count <= sat_inc(error_count);
                    if (error_count == '0) begin
                        first_err_index <= rx_count;
                        first_err_data  <= in_data;
                    end
                end
            end else begin
                watchdog <= watchdog + 16'd1;
                if (expire) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ready_valid_sink_checker.sv
// tb_ready_valid_sink_checker: scenario tasks with a beat scoreboard for the sink checker
module tb_ready_valid_sink_checker;
    localparam int N = 16;
    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready, busy, done, pass, timeout;
    logic [7:0] ready_pattern, in_data, first_err_data;
    logic [15:0] rx_count, error_count, first_err_index;
    int vectors = 0;
    int errors = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    ready_valid_sink_checker dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ready_pattern   (ready_pattern),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .rx_count        (rx_count),
        .error_count     (error_count),
        .first_err_index (first_err_index),
        .first_err_data  (first_err_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arms a run, then sends beats 0,1,2..; beat bad_idx carries bad_val; holds valid low
    // for gap cycles before the last beat; stops after stop_at beats or at done.
    task automatic stream(input logic [7:0] pat, input int bad_idx, input logic [7:0] bad_val,
                          input int stop_at, input int gap, output int cycles, output int beats);
        int idle;
        logic hs;
        logic [15:0] exp;
        idle = 0;
        ready_pattern = pat;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        beats = 0;
        while (!done && beats < stop_at && cycles < 200) begin
            in_valid = !(beats == N - 1 && idle < gap);
            if (!in_valid) idle++;
            in_data = (beats == bad_idx) ? bad_val : 8'(beats);
            vectors++;
            if (in_ready !== pat[cycles % 8]) begin
                errors++;
                $display("FAIL in_ready run cycle %0d: got %b want %b", cycles, in_ready, pat[cycles % 8]);
            end
            hs = in_valid && in_ready;
            if (hs) sb.push_back(16'(beats + 1));
            step();
            cycles++;
            if (hs) begin
                exp = sb.pop_front();
                vectors++;
                if (rx_count !== exp) begin
                    errors++;
                    $display("FAIL rx_count after beat %0d: got %0d want %0d", beats, rx_count, exp);
                end
                beats++;
            end
        end
        in_valid = 1'b0;
        if (cycles >= 200) begin
            errors++;
            $display("FAIL stream budget: no done within %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; ready_pattern = '0;
        step(); step();
        reset = 1'b0;
        vectors++;
        if ({busy, done, pass, timeout, in_ready, rx_count, error_count, first_err_index, first_err_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b want all zero",
                     {busy, done, pass, timeout, in_ready, rx_count, error_count, first_err_index, first_err_data});
        end
    endtask

    task automatic test_full_rate();
        int c, b;
        stream(8'hFF, -1, 8'h00, 100, 0, c, b);
        vectors++;
        if (c !== 16 || b !== 16) begin
            errors++; $display("FAIL full_rate timing: got %0d cycles %0d beats want 16/16", c, b);
        end
        vectors++;
        if ({done, pass, timeout, in_ready, busy} !== 5'b11000 || error_count !== 0) begin
            errors++; $display("FAIL full_rate status: got d%b p%b t%b r%b b%b e%0d want d1 p1 t0 r0 b0 e0",
                               done, pass, timeout, in_ready, busy, error_count);
        end
        in_valid = 1'b1; in_data = 8'h10;
        repeat (3) step();
        in_valid = 1'b0;
        vectors++;
        if (rx_count !== 16 || done !== 1'b1 || pass !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL done_hold: got rx %0d d%b p%b r%b want rx 16 d1 p1 r0", rx_count, done, pass, in_ready);
        end
    endtask

    task automatic test_alternate();
        int c, b;
        stream(8'h55, -1, 8'h00, 100, 0, c, b);
        vectors++;
        if (c !== 31 || b !== 16) begin
            errors++; $display("FAIL alternate timing: got %0d cycles %0d beats want 31/16", c, b);
        end
        vectors++;
        if (pass !== 1'b1 || rx_count !== 16) begin
            errors++; $display("FAIL alternate status: got p%b rx %0d want p1 rx 16", pass, rx_count);
        end
    endtask

    task automatic test_error();
        int c, b;
        stream(8'hFF, 5, 8'hAA, 100, 0, c, b);
        vectors++;
        if (error_count !== 1 || first_err_index !== 5 || first_err_data !== 8'hAA) begin
            errors++; $display("FAIL error capture: got cnt %0d idx %0d data %h want 1 5 aa",
                               error_count, first_err_index, first_err_data);
        end
        vectors++;
        if (done !== 1'b1 || pass !== 1'b0 || rx_count !== 16) begin
            errors++; $display("FAIL error status: got d%b p%b rx %0d want d1 p0 rx 16", done, pass, rx_count);
        end
    endtask

    task automatic test_timeout_zero_pattern();
        int c, b;
        stream(8'h00, -1, 8'h00, 100, 0, c, b);
        vectors++;
        if (c !== 64 || b !== 0) begin
            errors++; $display("FAIL zero_pattern timing: got %0d cycles %0d beats want 64/0", c, b);
        end
        vectors++;
        if ({done, timeout, pass} !== 3'b110 || rx_count !== 0) begin
            errors++; $display("FAIL zero_pattern status: got d%b t%b p%b rx %0d want d1 t1 p0 rx 0",
                               done, timeout, pass, rx_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int c, b;
        stream(8'hFF, -1, 8'h00, 8, 0, c, b);
        vectors++;
        if (busy !== 1'b1 || rx_count !== 8) begin
            errors++; $display("FAIL mid_run before reset: got b%b rx %0d want b1 rx 8", busy, rx_count);
        end
        reset = 1'b1; start = 1'b1; ready_pattern = 8'hFF;
        step();
        reset = 1'b0; start = 1'b0;
        step();
        vectors++;
        if ({busy, done, pass, timeout, in_ready, rx_count, error_count, first_err_index, first_err_data} !== '0) begin
            errors++; $display("FAIL mid_run reset outputs: got %b want all zero",
                               {busy, done, pass, timeout, in_ready, rx_count, error_count, first_err_index, first_err_data});
        end
        stream(8'hFF, -1, 8'h00, 100, 0, c, b);
        vectors++;
        if (pass !== 1'b1 || rx_count !== 16) begin
            errors++; $display("FAIL restart: got p%b rx %0d want p1 rx 16", pass, rx_count);
        end
    endtask

    task automatic test_last_beat_at_expiry();
        int c, b;
        stream(8'hFF, -1, 8'h00, 100, 63, c, b);
        vectors++;
        if (timeout !== 1'b0 || rx_count !== 16 || pass !== 1'b1 || c !== 79) begin
            errors++; $display("FAIL last_at_expiry: got t%b rx %0d p%b cyc %0d want t0 rx 16 p1 cyc 79",
                               timeout, rx_count, pass, c);
        end
    endtask

    task automatic test_expiry_before_last();
        int c, b;
        stream(8'hFF, -1, 8'h00, 100, 64, c, b);
        vectors++;
        if (timeout !== 1'b1 || rx_count !== 15 || pass !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL expiry_first: got t%b rx %0d p%b d%b want t1 rx 15 p0 d1",
                               timeout, rx_count, pass, done);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_alternate();
        test_error();
        test_timeout_zero_pattern();
        test_reset_mid_run();
        test_last_beat_at_expiry();
        test_expiry_before_last();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ready_valid_sink_checker.md
READY_VALID_SINK_CHECKER -- requirements
Module: ready_valid_sink_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 8, stream data width.
  NUM_EXPECTED, 16, beats to accept per run.
  START_VALUE, 0, expected data of the first beat.
  TIMEOUT, 64, cycles in RUN without a handshake before abort.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset. Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  rising-edge clock.
  reset  in  1  synchronous, active-high reset.
  start  in  1  one-cycle pulse that arms a run.
  ready_pattern  in  8  per-cycle ready mask; sampled at start.
  in_valid  in  1  upstream valid.
  in_data  in  DATA_WIDTH  upstream data.
  in_ready  out  1  downstream ready, driven from a register.
  busy  out  1  high in RUN.
  done  out  1  high in DONE.
  pass  out  1  done and error_count==0 and timeout==0.
  timeout  out  1  run aborted by the watchdog.
  rx_count  out  16  beats accepted in the current run.
  error_count  out  16  mismatching beats; saturates at 16'hFFFF.
  first_err_index  out  16  rx_count value at the first mismatch.
  first_err_data  out  DATA_WIDTH  data received at the first mismatch.

Function
REQ-003 A handshake SHALL occur on a rising edge where in_valid and in_ready are both high.
REQ-004 in_ready SHALL be a flop output with no combinational path from in_valid or in_data.
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 IDLE SHALL go to RUN on start; DONE SHALL go to RUN on start; start in RUN SHALL be ignored.
REQ-007 On entering RUN, the block SHALL:
  - clear rx_count, error_count, timeout, first_err_*, phase and watchdog;
  - latch ready_pattern into pat_q.
REQ-008 In RUN, phase SHALL increment mod 8 every cycle, independent of handshakes.
REQ-009 in_ready SHALL equal pat_q[phase] in RUN, one cycle after the phase value; in_ready SHALL be 0 in IDLE and DONE.
REQ-010 The first RUN cycle SHALL present in_ready=pat_q[0], registered on the start edge.
REQ-011 Each handshake SHALL compare in_data with (START_VALUE + rx_count) mod 2^DATA_WIDTH, then increment rx_count.
REQ-012 A mismatch SHALL increment error_count, saturating at 16'hFFFF.
REQ-013 The first mismatch of a run SHALL capture first_err_index and first_err_data; later mismatches SHALL not overwrite them.
REQ-014 The handshake bringing rx_count to NUM_EXPECTED SHALL move RUN to DONE, and in_ready SHALL be 0 on the next cycle.
REQ-015 The watchdog SHALL count RUN cycles without a handshake and reset to 0 on every handshake.
REQ-016 When the watchdog reaches TIMEOUT-1 with no handshake, the FSM SHALL go to DONE and set timeout=1.
REQ-017 If the final beat and the watchdog expiry fall in the same cycle, the final beat SHALL win: timeout=0 and the beat is counted.
REQ-018 ready_pattern=8'h00 SHALL always end in timeout.
REQ-019 in_valid without in_ready SHALL have no effect; in_data SHALL be ignored outside handshakes.
REQ-020 All status outputs SHALL hold their values in DONE until the next start.

Reset
REQ-021 Reset SHALL force state=IDLE and in_ready=0, and clear every status output, counter, phase, watchdog and first_err_* to 0.
REQ-022 Reset asserted mid-RUN SHALL abort the run with no DONE pulse; start coincident with reset SHALL be ignored.

Structure
REQ-023 The state enum (IDLE, RUN, DONE) SHALL live in the shared package ready_valid_pkg, alongside the ready/valid common types.
REQ-024 The optional sub-module rv_ready_pattern_gen SHALL contain pat_q, phase and the registered in_ready; the FSM, compare logic and counters SHALL stay in the top module.

Verification
REQ-025 The bench SHALL cover these directed scenarios, one line each:
  - Pattern 8'hFF with a continuous sender of 0..15 -> 16 beats on consecutive cycles; done on the cycle after beat 15; pass=1.
  - Pattern 8'h55 with a continuous sender -> in_ready alternates 1,0; 16 beats in about 32 cycles; pass=1.
  - Beat 5 sent as 8'hAA -> error_count=1, first_err_index=5, first_err_data=8'hAA, pass=0.
  - Pattern 8'h00 -> timeout=1 after 64 RUN cycles; rx_count=0; in_ready never asserted.
  - Reset after beat 7 -> all outputs 0; a new start followed by a full stream -> pass=1.
  - Sender idle until watchdog=63, then the final beat at expiry -> timeout=0, rx_count=16.
